// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and a two-digit BCD entry state machine.
// Define KEYPAD_BACKSPACE_EN to make key D delete the last entered digit.
module keypad_entry #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] value,
    output logic       value_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] BLANK    = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;
`ifdef KEYPAD_BACKSPACE_EN
    localparam logic [3:0] KEY_D    = 4'd13;
`endif

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       col;
    logic [15:0]      scan_map;
    logic [15:0]      prev_map;
    logic [15:0]      accepted_map;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [15:0]      full_map;
    logic [3:0]       press_idx;
    logic             col_last;
    logic             map_done;
    logic             accept;
    logic             one_hot;
    logic             press;
    logic [1:0]       state;
    logic [6:0]       tens_bin;
    logic [6:0]       commit_value;

    // Map index is col*4 + row; the table follows the physical keypad layout.
    function automatic logic [3:0] code_of(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd4;
            4'd2:    code = 4'd7;
            4'd3:    code = 4'd14;
            4'd4:    code = 4'd2;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd8;
            4'd7:    code = 4'd0;
            4'd8:    code = 4'd3;
            4'd9:    code = 4'd6;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd15;
            4'd12:   code = 4'd10;
            4'd13:   code = 4'd11;
            4'd14:   code = 4'd12;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign col_n    = ~(4'b0001 << col);
    assign col_last = (div == DIV_LAST);
    assign map_done = col_last && (col == 2'd3);
    assign full_map = {~row_sync, scan_map[11:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div      <= '0;
            col      <= 2'd0;
            scan_map <= '0;
        end else if (col_last) begin
            div                        <= '0;
            col                        <= col + 2'd1;
            scan_map[{col, 2'b00} +: 4] <= ~row_sync;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_comb begin
        cnt_next = CNT_W'(1);
        if (full_map == prev_map) begin
            cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
        end
    end

    assign accept  = map_done && (cnt_next == CNT_MAX);
    assign one_hot = (full_map != 16'd0) && ((full_map & (full_map - 16'd1)) == 16'd0);
    // Only a clean transition from nothing held to a single key counts as a press.
    assign press   = accept && (accepted_map == 16'd0) && one_hot;

    always_comb begin
        press_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_map[i]) press_idx = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_map     <= '0;
            stable_cnt   <= '0;
            accepted_map <= '0;
            key_strobe   <= 1'b0;
            key_code     <= 4'd0;
        end else begin
            key_strobe <= press;
            if (press) key_code <= code_of(press_idx);
            if (map_done) begin
                prev_map   <= full_map;
                stable_cnt <= cnt_next;
                if (accept) accepted_map <= full_map;
            end
        end
    end

    assign tens_bin     = (tens == BLANK) ? 7'd0 : {3'b000, tens};
    assign commit_value = tens_bin * 7'd10 + {3'b000, ones};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            tens        <= BLANK;
            ones        <= BLANK;
            value       <= 7'd0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (key_strobe) begin
                if (key_code <= 4'd9) begin
                    if (state == ST_EMPTY || state == ST_DONE) begin
                        state <= ST_ONE;
                        tens  <= BLANK;
                    end else begin
                        state <= ST_TWO;
                        tens  <= ones;
                    end
                    ones <= key_code;
                end else if (key_code == KEY_STAR) begin
                    state <= ST_EMPTY;
                    tens  <= BLANK;
                    ones  <= BLANK;
                end else if (key_code == KEY_HASH) begin
                    if (state != ST_EMPTY) begin
                        state       <= ST_DONE;
                        value       <= commit_value;
                        value_valid <= 1'b1;
                    end
`ifdef KEYPAD_BACKSPACE_EN
                end else if (key_code == KEY_D) begin
                    // A committed single digit has a blank tens, so it drops straight to empty.
                    if (state == ST_TWO || (state == ST_DONE && tens != BLANK)) begin
                        state <= ST_ONE;
                        ones  <= tens;
                        tens  <= BLANK;
                    end else if (state == ST_ONE || state == ST_DONE) begin
                        state <= ST_EMPTY;
                        tens  <= BLANK;
                        ones  <= BLANK;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: drives a 4x4 keypad model and compares against a
// digit-list model of the entry behaviour. Honours KEYPAD_BACKSPACE_EN.
module tb_keypad_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_strobe;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] value;
    logic       value_valid;

    logic [15:0] pressed;
    int keyAt [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    int checks = 0;
    int errors = 0;
    int digits[$];
    bit committed = 0;
    int expValue = 0;

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_n(row_n),
        .col_n(col_n),
        .key_code(key_code),
        .key_strobe(key_strobe),
        .tens(tens),
        .ones(ones),
        .value(value),
        .value_valid(value_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setKey(input int code, input bit on);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keyAt[r][c] == code) pressed[r*4+c] = on;
            end
        end
    endtask

    function automatic int modelTens();
        return (digits.size() == 2) ? digits[0] : 15;
    endfunction

    function automatic int modelOnes();
        return (digits.size() >= 1) ? digits[digits.size()-1] : 15;
    endfunction

    task automatic modelKey(input int code, output int validExp);
        validExp = 0;
        if (code <= 9) begin
            if (committed) digits.delete();
            committed = 0;
            digits.push_back(code);
            if (digits.size() > 2) void'(digits.pop_front());
        end else if (code == 14) begin
            digits.delete();
            committed = 0;
        end else if (code == 15) begin
            if (digits.size() > 0) begin
                expValue  = (digits.size() == 2) ? digits[0]*10 + digits[1] : digits[0];
                validExp  = 1;
                committed = 1;
            end
`ifdef KEYPAD_BACKSPACE_EN
        end else if (code == 13) begin
            if (digits.size() > 0) begin
                void'(digits.pop_back());
                committed = 0;
            end
`endif
        end
    endtask

    task automatic waitCountStrobes(input int cycles, inout int count);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (key_strobe) count++;
        end
    endtask

    task automatic applyStimulus(input int code);
        int waited = 0;
        bit seen = 0;
        int extra = 0;
        int validExp;
        setKey(code, 1'b1);
        while (!seen && waited < 100) begin
            @(negedge clk);
            waited++;
            if (key_strobe) seen = 1;
        end
        checkOutput($sformatf("strobe_seen_%0d", code), int'(seen), 1);
        modelKey(code, validExp);
        if (seen) begin
            checkOutput("key_code", int'(key_code), code);
            @(negedge clk);
            waited++;
            checkOutput("tens", int'(tens), modelTens());
            checkOutput("ones", int'(ones), modelOnes());
            checkOutput("value_valid", int'(value_valid), validExp);
            checkOutput("value", int'(value), expValue);
            @(negedge clk);
            waited++;
            checkOutput("strobe_width", int'(key_strobe), 0);
            checkOutput("valid_width", int'(value_valid), 0);
        end
        if (waited < 120) waitCountStrobes(120 - waited, extra);
        setKey(code, 1'b0);
        waitCountStrobes(120, extra);
        checkOutput("no_extra_strobe", extra, 0);
    endtask

    initial begin
        int strobes;
        int code;
        pressed = '0;
        rst_n   = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_col_n", int'(col_n), 14);
        checkOutput("rst_key_code", int'(key_code), 0);
        checkOutput("rst_key_strobe", int'(key_strobe), 0);
        checkOutput("rst_tens", int'(tens), 15);
        checkOutput("rst_ones", int'(ones), 15);
        checkOutput("rst_value", int'(value), 0);
        checkOutput("rst_value_valid", int'(value_valid), 0);

        $display("[TB] idle scan");
        rst_n   = 1'b1;
        strobes = 0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            if (key_strobe) strobes++;
            checkOutput($sformatf("col_n_%0d", k), int'(col_n), 15 ^ (1 << ((k / 4) % 4)));
        end
        waitCountStrobes(168, strobes);
        checkOutput("idle_strobes", strobes, 0);
        checkOutput("idle_tens", int'(tens), 15);
        checkOutput("idle_ones", int'(ones), 15);

        $display("[TB] enter 4 2 #");
        applyStimulus(4);
        applyStimulus(2);
        applyStimulus(15);
        checkOutput("value_42", int'(value), 42);

        $display("[TB] bounce on 7");
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            setKey(7, (i % 2) == 0);
            waitCountStrobes(5, strobes);
        end
        checkOutput("bounce_early_strobes", strobes, 0);
        applyStimulus(7);
        checkOutput("bounce_ones", int'(ones), 7);

        $display("[TB] multi-key 1+5");
        strobes = 0;
        setKey(1, 1'b1);
        setKey(5, 1'b1);
        waitCountStrobes(150, strobes);
        setKey(5, 1'b0);
        waitCountStrobes(150, strobes);
        setKey(1, 1'b0);
        waitCountStrobes(150, strobes);
        checkOutput("multi_strobes", strobes, 0);
        checkOutput("multi_ones", int'(ones), modelOnes());

        $display("[TB] enter 9 8 3 *");
        applyStimulus(9);
        applyStimulus(8);
        applyStimulus(3);
        checkOutput("seq_tens_8", int'(tens), 8);
        checkOutput("seq_ones_3", int'(ones), 3);
        applyStimulus(14);
        checkOutput("star_value_kept", int'(value), 42);

        $display("[TB] enter 6 1 D #");
        applyStimulus(6);
        applyStimulus(1);
        applyStimulus(13);
        applyStimulus(15);
`ifdef KEYPAD_BACKSPACE_EN
        checkOutput("backspace_value", int'(value), 6);
`else
        checkOutput("backspace_value", int'(value), 61);
`endif

        $display("[TB] random keys");
        for (int n = 0; n < 20; n++) begin
            code = int'($urandom_range(0, 15));
            applyStimulus(code);
        end
        applyStimulus(int'($urandom_range(1, 9)));
        applyStimulus(15);

        $display("[TB] reset mid-entry");
        applyStimulus(7);
        setKey(3, 1'b1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_col_n", int'(col_n), 14);
        checkOutput("midrst_tens", int'(tens), 15);
        checkOutput("midrst_ones", int'(ones), 15);
        checkOutput("midrst_value", int'(value), 0);
        setKey(3, 1'b0);
        rst_n = 1'b1;
        digits.delete();
        committed = 0;
        expValue  = 0;
        strobes   = 0;
        waitCountStrobes(150, strobes);
        checkOutput("midrst_strobes", strobes, 0);
        applyStimulus(5);
        applyStimulus(15);
        checkOutput("post_rst_value", int'(value), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
